// File: rtl/idli_uart_buf_m.sv
`default_nettype none
// ============================================================================
// Module      : idli_uart_buf_m
// Description : Byte-level UART buffer between the execution stage's
//               nibble-serial UART interface and the 8N1 serial pins.
//               TX: nibble pairs -> byte FIFO -> serialiser.
//               RX: synchroniser -> deserialiser -> byte FIFO -> nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module idli_uart_buf_m #(
    parameter int CLK_PER_BIT = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       i_ex_gck,
    input  logic       i_ex_rst_n,
    input  logic       i_uart_tx_vld,
    input  logic [3:0] i_uart_tx_data,
    output logic       o_uart_tx_rdy1,
    output logic       o_uart_tx_rdy2,
    output logic       o_uart_tx_ovf,
    input  logic       i_uart_rx_acp,
    output logic [3:0] o_uart_rx_data,
    output logic       o_uart_rx_rdy1,
    output logic       o_uart_rx_rdy2,
    output logic       o_uart_rx_ovf,
    output logic       o_uart_rx_ferr,
    output logic       o_uart_tx,
    input  logic       i_uart_rx
);
    localparam int              AW            = $clog2(FIFO_DEPTH);
    localparam int              FW            = AW + 1;
    localparam int              CW            = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]   C_BIT_RELOAD  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]   C_HALF_RELOAD = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [FW-1:0]   C_DEPTH       = FW'(FIFO_DEPTH);
    localparam logic [FW-1:0]   C_DEPTH_M1    = FW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // ---------------- TX side state ----------------
    logic          tx_nib_ptr_q;
    logic [3:0]    tx_nib_q;
    logic [FW-1:0] tx_wr_q, tx_rd_q;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    uart_state_e   tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_idx_q;
    logic [7:0]    tx_sh_q;
    logic          tx_line_q;
    logic          tx_ovf_q;

    logic          tx_push_w, tx_pop_w, tx_do_push_w, tx_drop_w;
    logic          tx_empty_w, tx_full_w;
    logic [FW-1:0] tx_count_w;
    logic [7:0]    tx_head_w, tx_byte_w;

    // ---------------- RX side state ----------------
    logic          rx_meta_q, rx_sync_q;
    uart_state_e   rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic [7:0]    rx_sh_q;
    logic [FW-1:0] rx_wr_q, rx_rd_q;
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic          rx_nib_ptr_q;
    logic          rx_ovf_q, rx_ferr_q;

    logic          rx_stop_smp_w, rx_push_w, rx_pop_w, rx_acp_ok_w;
    logic          rx_do_push_w, rx_drop_w;
    logic          rx_empty_w, rx_full_w;
    logic [FW-1:0] rx_count_w;
    logic [7:0]    rx_head_w;

    // TX FIFO status, push/pop qualification and byte assembly
    always_comb begin
        tx_byte_w    = {i_uart_tx_data, tx_nib_q};
        tx_push_w    = i_uart_tx_vld && tx_nib_ptr_q;
        tx_empty_w   = (tx_wr_q == tx_rd_q);
        tx_full_w    = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
        tx_count_w   = tx_wr_q - tx_rd_q;
        tx_head_w    = tx_mem_q[tx_rd_q[AW-1:0]];
        // The serialiser takes a byte when idle or at the end of a stop bit.
        tx_pop_w     = !tx_empty_w &&
                       ((tx_state_q == ST_IDLE) ||
                        ((tx_state_q == ST_STOP) && (tx_cnt_q == '0)));
        // A pop in the same cycle frees a slot, so a push onto full succeeds.
        tx_do_push_w = tx_push_w && (!tx_full_w || tx_pop_w);
        tx_drop_w    = tx_push_w && !tx_do_push_w;
    end

    // Low nibble is held until its high partner arrives
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            tx_nib_ptr_q <= 1'b0;
            tx_nib_q     <= 4'h0;
        end else if (i_uart_tx_vld) begin
            if (!tx_nib_ptr_q) begin
                tx_nib_q <= i_uart_tx_data;
            end
            tx_nib_ptr_q <= !tx_nib_ptr_q;
        end
    end

    // TX FIFO storage
    always_ff @(posedge i_ex_gck) begin
        if (tx_do_push_w) begin
            tx_mem_q[tx_wr_q[AW-1:0]] <= tx_byte_w;
        end
    end

    // TX FIFO pointers (extra wrap bit distinguishes full from empty)
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_do_push_w) tx_wr_q <= tx_wr_q + FW'(1);
            if (tx_pop_w)     tx_rd_q <= tx_rd_q + FW'(1);
        end
    end

    // TX serialiser: 8N1, LSB first, line value registered with the state
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    if (tx_pop_w) begin
                        tx_sh_q    <= tx_head_w;
                        tx_cnt_q   <= C_BIT_RELOAD;
                        tx_line_q  <= 1'b0;
                        tx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q   <= C_BIT_RELOAD;
                        tx_idx_q   <= 3'd0;
                        tx_line_q  <= tx_sh_q[0];
                        tx_state_q <= ST_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= C_BIT_RELOAD;
                        if (tx_idx_q == 3'd7) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= ST_STOP;
                        end else begin
                            tx_idx_q  <= tx_idx_q + 3'd1;
                            tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
                            tx_line_q <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_q == '0) begin
                        if (tx_pop_w) begin
                            // Back-to-back frame: no idle gap after the stop bit.
                            tx_sh_q    <= tx_head_w;
                            tx_cnt_q   <= C_BIT_RELOAD;
                            tx_line_q  <= 1'b0;
                            tx_state_q <= ST_START;
                        end else begin
                            tx_state_q <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser on the asynchronous RX pin, idles high
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // RX FIFO status, stop-bit decision and nibble delivery
    always_comb begin
        rx_stop_smp_w = (rx_state_q == ST_STOP) && (rx_cnt_q == '0);
        rx_push_w     = rx_stop_smp_w && rx_sync_q;
        rx_empty_w    = (rx_wr_q == rx_rd_q);
        rx_full_w     = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);
        rx_count_w    = rx_wr_q - rx_rd_q;
        rx_head_w     = rx_mem_q[rx_rd_q[AW-1:0]];
        rx_acp_ok_w   = i_uart_rx_acp && !rx_empty_w;
        rx_pop_w      = rx_acp_ok_w && rx_nib_ptr_q;
        rx_do_push_w  = rx_push_w && (!rx_full_w || rx_pop_w);
        rx_drop_w     = rx_push_w && !rx_do_push_w;
        o_uart_rx_data = rx_empty_w ? 4'h0 : (rx_nib_ptr_q ? rx_head_w[7:4] : rx_head_w[3:0]);
    end

    // RX deserialiser: half-bit start check, then mid-bit samples
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
        end else begin
            case (rx_state_q)
                ST_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_cnt_q   <= C_HALF_RELOAD;
                        rx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_sync_q) begin
                            rx_state_q <= ST_IDLE;   // glitch, not a start bit
                        end else begin
                            rx_cnt_q   <= C_BIT_RELOAD;
                            rx_idx_q   <= 3'd0;
                            rx_state_q <= ST_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                        rx_cnt_q <= C_BIT_RELOAD;
                        if (rx_idx_q == 3'd7) begin
                            rx_state_q <= ST_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q == '0) begin
                        rx_state_q <= ST_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge i_ex_gck) begin
        if (rx_do_push_w) begin
            rx_mem_q[rx_wr_q[AW-1:0]] <= rx_sh_q;
        end
    end

    // RX FIFO pointers and nibble pointer; acp on an empty FIFO is ignored
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_nib_ptr_q <= 1'b0;
        end else begin
            if (rx_do_push_w) rx_wr_q <= rx_wr_q + FW'(1);
            if (rx_pop_w)     rx_rd_q <= rx_rd_q + FW'(1);
            if (rx_acp_ok_w)  rx_nib_ptr_q <= !rx_nib_ptr_q;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            tx_ovf_q  <= tx_ovf_q | tx_drop_w;
            rx_ovf_q  <= rx_ovf_q | rx_drop_w;
            rx_ferr_q <= rx_ferr_q | (rx_stop_smp_w && !rx_sync_q);
        end
    end

    assign o_uart_tx      = tx_line_q;
    assign o_uart_tx_ovf  = tx_ovf_q;
    assign o_uart_tx_rdy1 = (tx_count_w < C_DEPTH);
    assign o_uart_tx_rdy2 = (tx_count_w < C_DEPTH_M1);
    assign o_uart_rx_ovf  = rx_ovf_q;
    assign o_uart_rx_ferr = rx_ferr_q;
    assign o_uart_rx_rdy1 = (rx_count_w != '0);
    assign o_uart_rx_rdy2 = (rx_count_w > FW'(1));

endmodule
`default_nettype wire

// File: doc/idli_uart_buf_m.md
Name: idli_uart_buf_m

Overview:
- Byte-level UART buffer between the execution stage's nibble-serial UART interface and the external UART pins.
- TX path: collects the 4b nibbles the execution stage emits on URX/UTX-style instructions into bytes, queues them, and serialises them as 8N1 on o_uart_tx.
- RX path: deserialises o/i_uart_rx frames into a byte FIFO and returns each byte as two nibbles when the execution stage accepts.
- Ready flags let decode stall UART instructions until enough bytes or space exist.

Parameters:
- CLK_PER_BIT, 8, gck cycles per UART bit; must be ≥4 and even.
- FIFO_DEPTH, 4, entries per direction (bytes); power of two, ≥2.

Ports:
- i_ex_gck  in  1  core gated clock.
- i_ex_rst_n  in  1  reset, asynchronous, active-low.
- i_uart_tx_vld  in  1  nibble from EX is valid this cycle (EX o_ex_uart_tx_vld).
- i_uart_tx_data  in  4  TX nibble (EX ALU output, sqi_data_t).
- o_uart_tx_rdy1  out  1  TX FIFO has ≥1 free entry.
- o_uart_tx_rdy2  out  1  TX FIFO has ≥2 free entries.
- o_uart_tx_ovf  out  1  sticky: a TX byte was dropped because the FIFO was full.
- i_uart_rx_acp  in  1  EX consumes the current RX nibble (EX o_ex_uart_rx_acp).
- o_uart_rx_data  out  4  current RX nibble to EX (sqi_data_t).
- o_uart_rx_rdy1  out  1  RX FIFO holds ≥1 byte.
- o_uart_rx_rdy2  out  1  RX FIFO holds ≥2 bytes.
- o_uart_rx_ovf  out  1  sticky: a received byte was dropped because the FIFO was full.
- o_uart_rx_ferr  out  1  sticky: stop bit sampled 0.
- o_uart_tx  out  1  serial TX line.
- i_uart_rx  in  1  serial RX line (asynchronous).

Behaviour:
Reset values:
- o_uart_tx=1; all sticky flags=0.
- Both FIFOs empty, so rdy1/rdy2 for RX=0 and for TX=1.
- o_uart_rx_data=0.
- Nibble pointers=0; both FSMs IDLE; RX synchroniser flops=1.
- Reset mid-frame aborts the frame immediately. The TX line returns high asynchronously.

TX nibble assembly:
- Nibble order is low nibble first.
- First vld nibble is held in a 4b register and the pointer set.
- Second vld nibble pushes {i_uart_tx_data, held} into the FIFO and clears the pointer.
- Push onto a full FIFO: byte discarded, o_uart_tx_ovf set; the pointer still clears.

TX FSM (IDLE, START, DATA, STOP):
- IDLE with FIFO non-empty: pop the head into the shift register and enter START. o_uart_tx=0 from the next cycle.
- Each state lasts CLK_PER_BIT cycles, counted by a baud counter that reloads on each state or bit change.
- DATA shifts 8 bits, LSB first, using a 3b index.
- STOP drives 1. Then return to IDLE, or go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap).
- Latency: a byte pushed at cycle N into an empty FIFO with the FSM idle drives the start bit from cycle N+2.

RX synchroniser and FSM (IDLE, START, DATA, STOP):
- i_uart_rx passes through a 2-flop synchroniser.
- IDLE: a synced 0 enters START.
- START: after CLK_PER_BIT/2 cycles, re-sample. If 1, treat as a glitch and return to IDLE; if 0, enter DATA.
- DATA: sample every CLK_PER_BIT cycles (mid-bit), 8 bits, LSB first.
- STOP: sample after CLK_PER_BIT cycles.
  - Sample 1: push the byte, or set o_uart_rx_ovf if the FIFO is full.
  - Sample 0: set o_uart_rx_ferr and discard the byte.
- Return to IDLE immediately after the stop sample; the next start edge can be detected from the following cycle.

RX nibble delivery:
- o_uart_rx_data = head[3:0] when the pointer is 0, head[7:4] when 1; 0 if the FIFO is empty.
- i_uart_rx_acp toggles the pointer. Acp with pointer=1 pops the head.
- Acp while empty is ignored (pointer unchanged).

FIFO rules:
- Read and write pointers carry one extra wrap bit.
- Full = indices equal and wrap bits differ; empty = pointers equal.
- Push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot, so the push succeeds) or empty with a push (the pop is ignored and the push lands).
- rdy flags are combinational from the occupancy count; they update the cycle after a push or pop.

Test Plan:
- TX single byte: with CLK_PER_BIT=4, drive vld nibbles 0x5 then 0xA. The line must show start 0, then bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), then stop 1, each bit 4 cycles; the start bit begins 2 cycles after the second nibble.
- TX overflow/back-to-back: push 5 bytes 0x01..0x05 in consecutive nibble pairs with the line busy. Required: 0x01–0x04 transmitted with no idle gap between frames, 0x05 dropped, o_uart_tx_ovf=1, o_uart_tx_rdy1=0 while 4 bytes are queued.
- RX byte and nibbles: a serial frame of 0x3C gives rx_rdy1=1 after the stop sample. The bench sees nibble 0xC, acp, then 0x3, acp; after that the FIFO is empty, rx_data=0 and rx_rdy1=0.
- RX errors: a start glitch of 1 cycle must not start a frame. A frame 0x7E with stop=0 sets o_uart_rx_ferr and pushes nothing. Five good frames with no acp set o_uart_rx_ovf, and the FIFO holds the first 4 bytes.
- Simultaneous push/pop: with the RX FIFO full, complete a stop bit on the same cycle as the second acp. Required: the pop and push both occur, no ovf, and occupancy stays 4.
- Reset mid-frame: assert i_ex_rst_n low during TX DATA bit 3. o_uart_tx must go to 1 immediately; after release, FIFOs are empty, flags are 0 and the TX FSM is IDLE.
